// File: rtl/br_lite_inject_arb.sv
// Local injection arbiter for the broadcast router.
// Picks one of NREQ local requesters round-robin, stamps the flit with this
// PE's sequential address and a running id, and runs the req/ack handshake
// with the router's local input port. It accepts both the single-cycle ack
// and the ack that is held until req drops.

package br_lite_pkg;

  localparam int BR_ID_W = 4;

  typedef logic [1:0] br_svc_t;

  localparam br_svc_t BR_SVC_ALL   = 2'd0;
  localparam br_svc_t BR_SVC_WRITE = 2'd1;
  localparam br_svc_t BR_SVC_CLEAR = 2'd2;
  localparam br_svc_t BR_SVC_READ  = 2'd3;

  typedef struct packed {
    br_svc_t              service;
    logic [15:0]          seq_source;
    logic [BR_ID_W-1:0]   id;
    logic [31:0]          data;
  } br_data_t;

endpackage

module br_lite_inject_arb
  import br_lite_pkg::*;
#(
  parameter logic [15:0] SEQ_ADDRESS = 16'd0,
  parameter int          NREQ        = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NREQ-1:0]      in_valid_i,
  input  br_data_t [NREQ-1:0]  in_flit_i,
  output logic [NREQ-1:0]      in_ready_o,
  output logic [NREQ-1:0]      err_o,
  output logic [NREQ-1:0]      sent_o,
  input  logic                 local_busy_i,
  output br_data_t             flit_o,
  output logic                 req_o,
  input  logic                 ack_i
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ARB,
    REQ,
    RELEASE
  } state_t;

  state_t             state_reg, state_next;
  logic [GW-1:0]      last_grant_reg, last_grant_next;
  logic [GW-1:0]      grant_reg, grant_next;
  logic [BR_ID_W-1:0] id_cnt_reg, id_cnt_next;
  br_data_t           flit_reg, flit_next;

  // Round-robin search: rotate the valid vector so that bit 0 is the index
  // just after the last grant; the first set bit is then the winner. The
  // shift amount is one bit wider than an index so last_grant+1 == NREQ
  // does not wrap to zero when NREQ is a power of two.
  logic [GW:0]        shamt;
  logic [NREQ-1:0]    valid_rot;
  logic               rr_found;
  logic [GW-1:0]      rr_idx;

  assign shamt     = {1'b0, last_grant_reg} + (GW+1)'(1);
  assign valid_rot = NREQ'({in_valid_i, in_valid_i} >> shamt);

  // Pick the first valid requester after last_grant and map it back to its index
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (!rr_found && valid_rot[j]) begin
        rr_found = 1'b1;
        rr_idx   = GW'((int'(last_grant_reg) + 1 + j) % NREQ);
      end
    end
  end

  // Next-state logic: arbitration, flit capture, handshake progress
  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    grant_next      = grant_reg;
    id_cnt_next     = id_cnt_reg;
    flit_next       = flit_reg;
    case (state_reg)
      IDLE: begin
        // A lingering ack from a previous (or reset-aborted) transfer must
        // clear before we start a new one, otherwise it would be taken as
        // the ack for the new flit.
        if ((in_valid_i != '0) && !local_busy_i && !ack_i) begin
          state_next = ARB;
        end
      end
      ARB: begin
        if (rr_found) begin
          last_grant_next = rr_idx;
          grant_next      = rr_idx;
          if (in_flit_i[rr_idx].service == BR_SVC_CLEAR) begin
            // Rejected: consumed with an error, nothing goes to the router.
            state_next = IDLE;
          end else begin
            flit_next            = in_flit_i[rr_idx];
            flit_next.seq_source = SEQ_ADDRESS;
            flit_next.id         = id_cnt_reg;
            state_next           = REQ;
          end
        end else begin
          // Requester withdrew before being served; nothing to do.
          state_next = IDLE;
        end
      end
      REQ: begin
        if (ack_i) begin
          id_cnt_next = id_cnt_reg + BR_ID_W'(1);
          state_next  = RELEASE;
        end
      end
      RELEASE: begin
        // Wait out a held ack so it is not mistaken for the next one.
        if (!ack_i) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers; reset makes requester 0 win first
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg      <= IDLE;
      last_grant_reg <= GW'(NREQ - 1);
      grant_reg      <= '0;
      id_cnt_reg     <= '0;
      flit_reg       <= '0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      grant_reg      <= grant_next;
      id_cnt_reg     <= id_cnt_next;
      flit_reg       <= flit_next;
    end
  end

  assign req_o  = (state_reg == REQ);
  assign flit_o = flit_reg;

  // Per-requester pulses. ready/err are only ever raised during the single
  // ARB cycle and sent only during REQ with ack, each for the granted index.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_pulse
      assign in_ready_o[gi] = (state_reg == ARB) && rr_found && (rr_idx == GW'(gi));
      assign err_o[gi]      = in_ready_o[gi] && (in_flit_i[gi].service == BR_SVC_CLEAR);
      assign sent_o[gi]     = (state_reg == REQ) && ack_i && (grant_reg == GW'(gi));
    end
  endgenerate

endmodule

// File: tb/tb_br_lite_inject_arb.sv
// Bench for br_lite_inject_arb: requester and router models run as
// background threads; expected flits are queued when loaded and compared
// when sent_o fires.

module tb_br_lite_inject_arb;
  import br_lite_pkg::*;

  localparam int          NREQ = 4;
  localparam logic [15:0] SEQ  = 16'hA5C3;

  typedef struct {
    int       idx;
    br_data_t flit;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     in_valid;
  br_data_t [NREQ-1:0] in_flit;
  logic [NREQ-1:0]     in_ready;
  logic [NREQ-1:0]     err;
  logic [NREQ-1:0]     sent;
  logic                local_busy;
  br_data_t            flit;
  logic                req;
  logic                ack;

  int total = 0;
  int bad   = 0;

  exp_t         exp_q[$];
  int           err_exp_q[$];
  int           sent_cyc_q[$];
  br_svc_t      pend_svc[NREQ][64];
  logic [31:0]  pend_data[NREQ][64];
  int           pend_len[NREQ];
  int           rdy_cnt[NREQ];
  int           sent_seen;
  int           err_seen;
  int           cyc;
  logic [BR_ID_W-1:0] exp_id;
  br_data_t     last_exp_flit;
  bit           auto_ack;

  br_lite_inject_arb #(
    .SEQ_ADDRESS (SEQ),
    .NREQ        (NREQ)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .in_valid_i   (in_valid),
    .in_flit_i    (in_flit),
    .in_ready_o   (in_ready),
    .err_o        (err),
    .sent_o       (sent),
    .local_busy_i (local_busy),
    .flit_o       (flit),
    .req_o        (req),
    .ack_i        (ack)
  );

  always #5 clk = ~clk;

  // Queue a flit on requester i (presented by the requester thread)
  task automatic load(input int i, input br_svc_t svc, input logic [31:0] d);
    pend_svc[i][pend_len[i]]  = svc;
    pend_data[i][pend_len[i]] = d;
    pend_len[i]++;
  endtask

  // Expected router-side flit for a send from requester i
  task automatic push_exp(input int i, input br_svc_t svc, input logic [31:0] d);
    exp_t x;
    x.idx             = i;
    x.flit.service    = svc;
    x.flit.seq_source = SEQ;
    x.flit.id         = exp_id;
    x.flit.data       = d;
    exp_q.push_back(x);
    last_exp_flit = x.flit;
    exp_id++;
  endtask

  function automatic bit all_consumed();
    for (int i = 0; i < NREQ; i++) if (rdy_cnt[i] < pend_len[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Requesters: present the next pending flit, advance after in_ready
  task automatic drive_requesters();
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (rdy_cnt[i] < pend_len[i]) begin
          in_valid[i]           = 1'b1;
          in_flit[i].service    = pend_svc[i][rdy_cnt[i]];
          in_flit[i].seq_source = 16'hDEAD;
          in_flit[i].id         = BR_ID_W'(11);
          in_flit[i].data       = pend_data[i][rdy_cnt[i]];
        end else begin
          in_valid[i] = 1'b0;
        end
      end
    end
  endtask

  // Router: single-cycle ack for each req when enabled
  task automatic router();
    forever begin
      @(posedge clk);
      #1;
      if (auto_ack) ack = req && !ack;
    end
  endtask

  // Output monitor and scoreboard
  task automatic monitor();
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        for (int i = 0; i < NREQ; i++) if (in_ready[i]) rdy_cnt[i]++;
        if (in_ready != '0 || err != '0 || sent != '0) begin
          total++;
          if (!$onehot0(in_ready) || !$onehot0(err) || !$onehot0(sent)) begin
            bad++;
            $display("FAIL onehot: ready=%b err=%b sent=%b, each must have at most one bit", in_ready, err, sent);
          end
        end
        if (err != '0) begin
          int e;
          err_seen++;
          total++;
          if (err_exp_q.size() == 0) begin
            bad++;
            $display("FAIL err_unexpected: err=%b, none expected", err);
          end else begin
            e = err_exp_q.pop_front();
            if (err !== NREQ'(1 << e) || in_ready !== err) begin
              bad++;
              $display("FAIL err_pulse: err=%b ready=%b, required both %b", err, in_ready, NREQ'(1 << e));
            end
          end
        end
        if (sent != '0) begin
          exp_t x;
          sent_seen++;
          sent_cyc_q.push_back(cyc);
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL sent_unexpected: sent=%b flit=%h, none expected", sent, flit);
          end else begin
            x = exp_q.pop_front();
            if (sent !== NREQ'(1 << x.idx) || flit !== x.flit || req !== 1'b1) begin
              bad++;
              $display("FAIL sent_flit: sent=%b flit=%h req=%b, required sent=%b flit=%h req=1",
                       sent, flit, req, NREQ'(1 << x.idx), x.flit);
            end
          end
        end
      end
    end
  endtask

  // Wait until every expectation is consumed and the handshake is idle
  task automatic wait_drain(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < max_cyc; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && err_exp_q.size() == 0 && !req && all_consumed()) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    exp_id = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (req !== 1'b0)      begin bad++; $display("FAIL reset_req: req=%b required 0", req); end
    total++; if (flit !== '0)       begin bad++; $display("FAIL reset_flit: flit=%h required 0", flit); end
    total++; if (in_ready !== '0)   begin bad++; $display("FAIL reset_ready: ready=%b required 0", in_ready); end
    total++; if (err !== '0)        begin bad++; $display("FAIL reset_err: err=%b required 0", err); end
    total++; if (sent !== '0)       begin bad++; $display("FAIL reset_sent: sent=%b required 0", sent); end
    @(posedge clk);
    #1;
    rst    = 1'b0;
    exp_id = '0;
    $display("test_reset done");
  endtask

  task automatic test_single_write();
    int lat;
    int s0;
    bit ok;
    apply_reset();
    auto_ack = 1'b0;
    ack      = 1'b0;
    s0       = sent_seen;
    @(negedge clk);
    push_exp(0, BR_SVC_ALL, 32'h1111_0001);
    load(0, BR_SVC_ALL, 32'h1111_0001);
    @(posedge clk);
    #2;
    lat = -1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (req) begin lat = n; break; end
    end
    total++; if (lat !== 2) begin bad++; $display("FAIL single_latency: req after %0d cycles, required 2", lat); end
    @(posedge clk);
    #1 ack = 1'b1;
    @(negedge clk);
    total++; if (req !== 1'b1) begin bad++; $display("FAIL single_req_hold: req=%b required 1", req); end
    repeat (3) @(posedge clk);
    #1 ack = 1'b0;
    @(negedge clk);
    total++; if (req !== 1'b0) begin bad++; $display("FAIL single_release: req=%b required 0", req); end
    wait_drain(20, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_drain: timeout, required drain"); end
    total++; if (sent_seen - s0 !== 1) begin bad++; $display("FAIL single_sent_count: %0d sends, required 1", sent_seen - s0); end
    // Second flit must carry id 1
    @(negedge clk);
    auto_ack = 1'b1;
    push_exp(1, BR_SVC_WRITE, 32'h1111_0002);
    load(1, BR_SVC_WRITE, 32'h1111_0002);
    wait_drain(30, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_second_drain: timeout, required drain"); end
    $display("test_single_write done");
  endtask

  task automatic test_round_robin();
    bit ok;
    apply_reset();
    auto_ack = 1'b1;
    @(negedge clk);
    sent_cyc_q.delete();
    load(0, BR_SVC_ALL,   32'hA000_0000);
    load(0, BR_SVC_WRITE, 32'hA000_0001);
    load(1, BR_SVC_WRITE, 32'hB000_0000);
    load(2, BR_SVC_READ,  32'hC000_0000);
    load(3, BR_SVC_ALL,   32'hD000_0000);
    push_exp(0, BR_SVC_ALL,   32'hA000_0000);
    push_exp(1, BR_SVC_WRITE, 32'hB000_0000);
    push_exp(2, BR_SVC_READ,  32'hC000_0000);
    push_exp(3, BR_SVC_ALL,   32'hD000_0000);
    push_exp(0, BR_SVC_WRITE, 32'hA000_0001);
    wait_drain(60, ok);
    total++; if (!ok) begin bad++; $display("FAIL rr_drain: timeout, required drain"); end
    total++; if (sent_cyc_q.size() !== 5) begin bad++; $display("FAIL rr_count: %0d sends, required 5", sent_cyc_q.size()); end
    for (int k = 1; k < sent_cyc_q.size(); k++) begin
      total++;
      if (sent_cyc_q[k] - sent_cyc_q[k-1] !== 4) begin
        bad++;
        $display("FAIL rr_spacing: gap %0d cycles, required 4", sent_cyc_q[k] - sent_cyc_q[k-1]);
      end
    end
    $display("test_round_robin done");
  endtask

  task automatic test_busy_gating();
    int lat;
    bit blocked_ok;
    bit ok;
    auto_ack   = 1'b1;
    @(negedge clk);
    local_busy = 1'b1;
    push_exp(1, BR_SVC_WRITE, 32'hBB00_0001);
    load(1, BR_SVC_WRITE, 32'hBB00_0001);
    blocked_ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (req || in_ready != '0) blocked_ok = 1'b0;
    end
    total++; if (!blocked_ok) begin bad++; $display("FAIL busy_block: req/ready seen while busy, required none"); end
    @(posedge clk);
    #1 local_busy = 1'b0;
    lat = -1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (req) begin lat = n; break; end
    end
    total++; if (lat !== 2) begin bad++; $display("FAIL busy_release_latency: req after %0d cycles, required 2", lat); end
    // Busy rising mid-transfer must not abort it
    local_busy = 1'b1;
    wait_drain(20, ok);
    total++; if (!ok) begin bad++; $display("FAIL busy_midtransfer: timeout, required completion"); end
    local_busy = 1'b0;
    $display("test_busy_gating done");
  endtask

  task automatic test_clear_reject();
    int  e0;
    bit  saw_req;
    bit  ok;
    auto_ack = 1'b1;
    @(negedge clk);
    e0 = err_seen;
    err_exp_q.push_back(2);
    load(2, BR_SVC_CLEAR, 32'hCC00_0001);
    saw_req = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (req) saw_req = 1'b1;
    end
    total++; if (saw_req !== 1'b0) begin bad++; $display("FAIL clear_req: req asserted, required never"); end
    total++; if (err_seen - e0 !== 1) begin bad++; $display("FAIL clear_err_count: %0d err pulses, required 1", err_seen - e0); end
    total++; if (flit !== last_exp_flit) begin bad++; $display("FAIL clear_flit_kept: flit=%h required %h", flit, last_exp_flit); end
    // id counter untouched by the rejection
    push_exp(3, BR_SVC_ALL, 32'hCC00_0002);
    load(3, BR_SVC_ALL, 32'hCC00_0002);
    wait_drain(30, ok);
    total++; if (!ok) begin bad++; $display("FAIL clear_followup: timeout, required drain"); end
    $display("test_clear_reject done");
  endtask

  task automatic test_id_wrap();
    int s0;
    bit ok;
    apply_reset();
    auto_ack = 1'b1;
    s0       = sent_seen;
    @(negedge clk);
    for (int k = 0; k < 17; k++) begin
      br_svc_t svc;
      svc = (k % 2 == 0) ? BR_SVC_ALL : BR_SVC_WRITE;
      push_exp(0, svc, 32'h1D00_0000 + 32'(k));
      load(0, svc, 32'h1D00_0000 + 32'(k));
    end
    wait_drain(200, ok);
    total++; if (!ok) begin bad++; $display("FAIL wrap_drain: timeout, required drain"); end
    total++; if (sent_seen - s0 !== 17) begin bad++; $display("FAIL wrap_count: %0d sends, required 17", sent_seen - s0); end
    $display("test_id_wrap done");
  endtask

  task automatic test_reset_in_req();
    bit got_req;
    bit quiet_ok;
    int lat;
    bit ok;
    apply_reset();
    auto_ack = 1'b0;
    ack      = 1'b0;
    @(negedge clk);
    push_exp(0, BR_SVC_ALL, 32'hEE00_0001);
    load(0, BR_SVC_ALL, 32'hEE00_0001);
    got_req = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (req) begin got_req = 1'b1; break; end
    end
    total++; if (!got_req) begin bad++; $display("FAIL rstreq_reach: req=0, required 1 before reset"); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    ack = 1'b1;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    total++; if (req !== 1'b0) begin bad++; $display("FAIL rstreq_drop: req=%b required 0", req); end
    exp_id = '0;
    push_exp(0, BR_SVC_ALL, 32'hEE00_0002);
    load(0, BR_SVC_ALL, 32'hEE00_0002);
    @(posedge clk);
    #1 rst = 1'b0;
    quiet_ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (req || in_ready != '0 || sent != '0) quiet_ok = 1'b0;
    end
    total++; if (!quiet_ok) begin bad++; $display("FAIL rstreq_stale_ack: activity while ack stuck, required none"); end
    @(posedge clk);
    #1 ack = 1'b0;
    lat = -1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (req) begin lat = n; break; end
    end
    total++; if (lat !== 2) begin bad++; $display("FAIL rstreq_latency: req after %0d cycles, required 2", lat); end
    auto_ack = 1'b1;
    wait_drain(30, ok);
    total++; if (!ok) begin bad++; $display("FAIL rstreq_drain: timeout, required drain"); end
    $display("test_reset_in_req done");
  endtask

  initial begin
    rst        = 1'b1;
    ack        = 1'b0;
    local_busy = 1'b0;
    auto_ack   = 1'b0;
    in_valid   = '0;
    in_flit    = '0;
    exp_id     = '0;
    last_exp_flit = '0;
    sent_seen  = 0;
    err_seen   = 0;
    cyc        = 0;
    for (int i = 0; i < NREQ; i++) begin
      pend_len[i] = 0;
      rdy_cnt[i]  = 0;
    end
    fork
      drive_requesters();
      router();
      monitor();
    join_none

    test_reset();
    test_single_write();
    test_round_robin();
    test_busy_gating();
    test_clear_reject();
    test_id_wrap();
    test_reset_in_req();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/br_lite_inject_arb.md
BR_LITE_INJECT_ARB -- requirements
Module: br_lite_inject_arb

Interface
REQ-001 SHALL have parameter SEQ_ADDRESS, logic [15:0], default 0: sequential address of the local PE; stamped into seq_source.
REQ-002 SHALL have parameter NREQ, default 4, range 2..8: number of local requesters.
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk_i  input  1  clock; all state updates on its rising edge.
REQ-005 rst_i  input  1  synchronous active-high reset.
REQ-006 in_valid_i  input  NREQ  per-requester flit-valid.
REQ-007 in_flit_i  input  br_data_t[NREQ]  requester flits; seq_source and id fields are ignored.
REQ-008 in_ready_o  output  NREQ  one-cycle pulse; the flit was consumed.
REQ-009 err_o  output  NREQ  one-cycle pulse; the flit was rejected (service BR_SVC_CLEAR).
REQ-010 sent_o  output  NREQ  one-cycle pulse; the router acked the flit.
REQ-011 local_busy_i  input  1  router local_busy_o; high while the last local broadcast awaits auto-clear.
REQ-012 flit_o  output  br_data_t  flit to router local input (flit_i[BR_LOCAL]).
REQ-013 req_o  output  1  request to router local input (req_i[BR_LOCAL]).
REQ-014 ack_i  input  1  router ack_o[BR_LOCAL].

Function
REQ-015 SHALL implement FSM states IDLE, ARB, REQ, RELEASE.
REQ-016 IDLE->ARB SHALL occur when (in_valid_i != 0) && !local_busy_i && !ack_i; otherwise SHALL stay in IDLE.
REQ-017 In ARB, SHALL grant round-robin: the first valid index strictly after last_grant, wrapping modulo NREQ; last_grant SHALL update to the granted index.
REQ-018 In ARB, SHALL latch flit_o = in_flit_i[g], with seq_source = SEQ_ADDRESS and id = id_cnt.
REQ-019 In ARB, SHALL pulse in_ready_o[g] for exactly one cycle.
REQ-020 In ARB, if in_flit_i[g].service == BR_SVC_CLEAR, SHALL also pulse err_o[g], leave flit_o and id_cnt unchanged, and go to IDLE.
REQ-021 In ARB, for any other service, SHALL go to REQ.
REQ-022 In REQ, req_o SHALL be 1 and flit_o SHALL be stable.
REQ-023 REQ->RELEASE SHALL occur on the cycle ack_i == 1; that cycle SHALL pulse sent_o[g] and increment id_cnt.
REQ-024 id_cnt SHALL be $bits(id) wide and wrap from all-ones to 0.
REQ-025 In RELEASE, req_o SHALL be 0; RELEASE->IDLE SHALL occur when ack_i == 0.
REQ-026 This handshake SHALL cover both router ack forms: a single-cycle ack (duplicate ignored) and an ack held until req drops (write).
REQ-027 Latency: valid sampled in IDLE at edge t -> ARB in cycle t+1 -> req_o high from cycle t+2.
REQ-028 Minimum spacing between two injections SHALL be 4 cycles.
REQ-029 Requesters SHALL hold in_valid_i and in_flit_i until in_ready_o; behaviour for a valid withdrawn earlier is unspecified.
REQ-030 local_busy_i rising while in REQ/RELEASE SHALL NOT abort the transfer; it SHALL only block the next IDLE->ARB.
REQ-031 Only the granted index SHALL ever see in_ready_o, err_o or sent_o; at most one bit of each vector SHALL be set per cycle.
REQ-032 ack_i high in IDLE or ARB (stale) SHALL be ignored and SHALL never produce sent_o.
REQ-033 Non-granted valid requesters SHALL wait with no starvation; worst case NREQ-1 grants.

Reset
REQ-034 While rst_i is high at a clock edge: state=IDLE, req_o=0, flit_o='0, in_ready_o=0, err_o=0, sent_o=0, id_cnt=0, last_grant=NREQ-1 (requester 0 wins first).
REQ-035 Reset mid-REQ SHALL drop req_o the next cycle; after reset, a new request SHALL wait in IDLE until ack_i is 0 (REQ-016).

Verification
REQ-036 Single write: reset; in_valid_i=4'b0001, service BR_SVC_ALL; ack_i held high 3 cycles after req_o, then low -> req_o high at t+2; flit_o.seq_source=SEQ_ADDRESS, id=0; sent_o[0] pulses once; id_cnt=1; back to IDLE.
REQ-037 Round-robin: in_valid_i=4'b1111 held, auto-ack -> grant order 0,1,2,3,0; ids 0,1,2,3,4.
REQ-038 Busy gating: local_busy_i=1 with in_valid_i=4'b0010 for 20 cycles -> req_o stays 0; local_busy_i->0 -> req_o high 2 cycles later.
REQ-039 Clear rejection: in_valid_i[2]=1, service BR_SVC_CLEAR -> in_ready_o[2] and err_o[2] pulse together; req_o never asserts; id_cnt unchanged.
REQ-040 ID wrap: preload id_cnt to all-ones via repeated sends -> next flit carries all-ones id; the following flit carries id 0.
REQ-041 Reset in REQ with ack_i stuck high 5 cycles after reset and in_valid_i=4'b0001 -> no req_o until ack_i=0; then normal injection with id=0.
